// File: rtl/mote_framer_if.sv
// Framer bus: two request/ack payload sources, the timestamp, and the UART byte handshake.
interface mote_framer_if;
  logic       req_a;
  logic [7:0] data_a;
  logic       ack_a;
  logic       req_b;
  logic [7:0] data_b;
  logic       ack_b;
  logic [15:0] timestamp;
  logic       txd_busy;
  logic       txd_start;
  logic [7:0] txd_data;
  logic       frame_active;

  modport master (
    output req_a, data_a, req_b, data_b, timestamp, txd_busy,
    input  ack_a, ack_b, txd_start, txd_data, frame_active
  );

  modport slave (
    input  req_a, data_a, req_b, data_b, timestamp, txd_busy,
    output ack_a, ack_b, txd_start, txd_data, frame_active
  );
endinterface

// File: rtl/mote_framer.sv
// Round-robin framer: accepts one payload byte from A or B and sends a 6-byte
// frame (sync, id, ts_hi, ts_lo, payload, xor checksum) to a byte UART.
module mote_framer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] ID_A      = 8'h01,
  parameter logic [7:0] ID_B      = 8'h02
) (
  input logic          clk50,
  input logic          reset,
  mote_framer_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_HOLD, ST_WAIT} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic        last_b;
  logic [7:0]  id_q;
  logic [15:0] ts_q;
  logic [7:0]  pay_q;
  logic        grant_a;
  logic [7:0]  cur_byte;
  logic [7:0]  checksum;

  // NOTE: every variable gets a value before the case so no latch is inferred.
  always_comb begin
    grant_a  = bus.req_a && (!bus.req_b || last_b);
    checksum = id_q ^ ts_q[15:8] ^ ts_q[7:0] ^ pay_q;
    cur_byte = checksum;
    case (idx)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = id_q;
      3'd2:    cur_byte = ts_q[15:8];
      3'd3:    cur_byte = ts_q[7:0];
      3'd4:    cur_byte = pay_q;
      default: cur_byte = checksum;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      idx              <= 3'd0;
      last_b           <= 1'b1;
      // NOTE: the frame registers are few and reset to zero, unlike a memory array.
      id_q             <= 8'h00;
      ts_q             <= 16'h0000;
      pay_q            <= 8'h00;
      bus.ack_a        <= 1'b0;
      bus.ack_b        <= 1'b0;
      bus.txd_start    <= 1'b0;
      bus.txd_data     <= 8'h00;
      bus.frame_active <= 1'b0;
    end else begin
      bus.ack_a     <= 1'b0;
      bus.ack_b     <= 1'b0;
      bus.txd_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_a || bus.req_b) begin
            bus.ack_a        <= grant_a;
            bus.ack_b        <= !grant_a;
            last_b           <= !grant_a;
            id_q             <= grant_a ? ID_A : ID_B;
            pay_q            <= grant_a ? bus.data_a : bus.data_b;
            ts_q             <= bus.timestamp;
            idx              <= 3'd0;
            bus.frame_active <= 1'b1;
            state            <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!bus.txd_busy) begin
            bus.txd_start <= 1'b1;
            bus.txd_data  <= cur_byte;
            state         <= ST_HOLD;
          end
        end
        // HOLD gives the UART one cycle to raise busy before it is sampled.
        ST_HOLD: state <= ST_WAIT;
        ST_WAIT: begin
          if (!bus.txd_busy) begin
            if (idx < 3'd5) begin
              idx   <= idx + 3'd1;
              state <= ST_SEND;
            end else begin
              bus.frame_active <= 1'b0;
              state            <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mote_framer.md
MOTE_FRAMER -- requirements
Module: mote_framer

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: first byte of every frame.
REQ-002 Parameter ID_A, default 8'h01: mote identifier byte for source A.
REQ-003 Parameter ID_B, default 8'h02: mote identifier byte for source B.
REQ-004 clk50  input  1: the one clock; all state changes on its rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 req_a  input  1: source A holds a valid payload byte; held high until ack_a.
REQ-007 data_a  input  8: source A payload byte, stable while req_a is high.
REQ-008 req_b  input  1: source B holds a valid payload byte; held high until ack_b.
REQ-009 data_b  input  8: source B payload byte, stable while req_b is high.
REQ-010 timestamp  input  16: free-running microsecond count.
REQ-011 txd_busy  input  1: downstream UART transmitter busy.
REQ-012 ack_a  output  1: one-cycle pulse; A's byte is accepted.
REQ-013 ack_b  output  1: one-cycle pulse; B's byte is accepted.
REQ-014 txd_start  output  1: one-cycle pulse; load txd_data into the UART.
REQ-015 txd_data  output  8: byte for the UART, stable from txd_start until the next txd_start.
REQ-016 frame_active  output  1: high while a frame is in progress (any state other than IDLE).

Function
REQ-017 Frame: 6 bytes, in this order:
- SYNC_BYTE
- ID
- timestamp[15:8]
- timestamp[7:0]
- payload
- checksum = XOR of bytes 2..5 (ID, ts_hi, ts_lo, payload)
REQ-018 States: IDLE, SEND, HOLD, WAIT.
REQ-019 IDLE: when req_a or req_b is high, perform the following in one cycle, then go to SEND:
- grant one source (see REQ-020, REQ-021);
- pulse its ack;
- latch ID, the payload byte and the current timestamp into frame registers;
- clear the byte index to 0.
REQ-020 Arbitration is round-robin: with both requests high, grant the source not granted last.
REQ-021 The last-granted pointer resets to B, so A wins the first contention after reset.
REQ-022 SEND: if txd_busy is low, pulse txd_start for one cycle with txd_data = byte[index], then go to HOLD; if txd_busy is high, stay in SEND.
REQ-023 HOLD: lasts exactly one cycle, ignores txd_busy, then goes to WAIT.
REQ-024 WAIT: stay while txd_busy is high; when txd_busy is low, go to SEND with index+1 if index < 5, else go to IDLE.
REQ-025 Minimum frame time: 6 bytes x (SEND + HOLD + at least one WAIT cycle), plus the UART busy time.
REQ-026 ack_a/ack_b are issued only in IDLE, at most one per cycle, and never twice for the same frame.
REQ-027 Requests arriving mid-frame are not acknowledged until the machine returns to IDLE; requests are never dropped.
REQ-028 The timestamp is sampled in the acceptance cycle only; later timestamp changes do not alter the frame.
REQ-029 The checksum is computed from the latched registers; it is fixed for the whole frame.
REQ-030 Timestamp wrap (16'hFFFF to 16'h0000) needs no special handling; the sampled value is sent as-is.
REQ-031 txd_start is never high in two consecutive cycles.

Reset
REQ-032 Reset is asynchronous and active-high; it takes effect immediately, without waiting for clk50.
REQ-033 Reset values:
- state = IDLE
- ack_a = ack_b = 0
- txd_start = 0
- txd_data = 8'h00
- frame_active = 0
- byte index = 0
- last-granted = B
- frame registers = 0
REQ-034 Reset mid-frame abandons the frame: no further txd_start until a new request is accepted after reset deasserts.
REQ-035 No state or output changes while reset is high, regardless of requests or txd_busy.

Verification
REQ-036 Single request, fast UART:
- Stimulus: req_a=1, data_a=8'h3C, timestamp=16'h1234; UART model holds busy for 10 cycles after each start.
- Response: one ack_a; txd_data sequence A5,01,12,34,3C,1B; frame_active falls after the 6th byte.
REQ-037 Simultaneous requests:
- Stimulus: req_a and req_b both high after reset, data_a=8'h00, data_b=8'hFF.
- Response: A's frame is sent first, then B's frame (A5,02,ts_hi,ts_lo,FF,checksum); ack_b is not pulsed before A's 6th byte completes.
REQ-038 Round-robin:
- Stimulus: both requests held continuously for 4 frames.
- Response: frame IDs go 01,02,01,02.
REQ-039 Busy stall:
- Stimulus: hold txd_busy high for 200 cycles before the first SEND.
- Response: no txd_start until busy falls; then exactly one start.
- Also check: timestamp changed during the stall is not reflected in the frame.
REQ-040 Reset mid-frame:
- Stimulus: assert reset after the 3rd txd_start.
- Response: outputs take their reset values immediately; no further txd_start; the next frame begins with A5.
REQ-041 Wrap:
- Stimulus: timestamp=16'hFFFF at acceptance.
- Response: bytes 3-4 = FF,FF; checksum = ID^payload (the two FF bytes cancel).
